// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter: shares the external memory bus between the CPU and three
// DMA masters. The bus is parked on the CPU. The CPU is halted through the
// HALT/BA handshake before any DMA grant. Video DMA has fixed top priority and
// is never preempted. The two secondary requesters alternate round-robin and
// are burst-limited while another master is waiting.
module vram_bus_arbiter #(
    parameter int unsigned HALT_TIMEOUT = 64,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned CW           = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_ba,
    output logic       cpu_halt,
    input  logic       vid_req,
    output logic       vid_gnt,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] bus_sel,
    output logic       timeout_err
);

    // FSM encoding
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HALTING = 3'd1;
    localparam logic [2:0] S_GRANT   = 3'd2;
    localparam logic [2:0] S_OWNED   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    // Bus owner select codes
    localparam logic [1:0] SEL_CPU = 2'd0;
    localparam logic [1:0] SEL_VID = 2'd1;
    localparam logic [1:0] SEL_R0  = 2'd2;
    localparam logic [1:0] SEL_R1  = 2'd3;

    // Terminal counts for the shared counter
    localparam logic [CW-1:0] HALT_LAST  = CW'(HALT_TIMEOUT - 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rr, rr_n;
    logic          cpu_halt_n;
    logic          vid_gnt_n;
    logic [1:0]    gnt_n;
    logic [1:0]    bus_sel_n;
    logic          timeout_err_n;

    logic          any_req;
    logic          own_idx;
    logic          own_req;
    logic          other_req;
    logic          burst_done;

    // Request summary and current secondary owner (bus_sel 2 -> req0, 3 -> req1)
    always_comb begin
        any_req    = vid_req | req[0] | req[1];
        own_idx    = bus_sel[0];
        own_req    = req[own_idx];
        other_req  = req[~own_idx];
        burst_done = (cnt >= BURST_LAST);
    end

    // Next-state and next-output logic
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        rr_n          = rr;
        cpu_halt_n    = cpu_halt;
        vid_gnt_n     = vid_gnt;
        gnt_n         = gnt;
        bus_sel_n     = bus_sel;
        timeout_err_n = 1'b0;

        case (state)
            S_IDLE: begin
                cpu_halt_n = 1'b0;
                vid_gnt_n  = 1'b0;
                gnt_n      = 2'b00;
                bus_sel_n  = SEL_CPU;
                if (any_req) begin
                    state_n    = S_HALTING;
                    cpu_halt_n = 1'b1;
                    cnt_n      = '0;
                end
            end

            S_HALTING: begin
                cpu_halt_n = 1'b1;
                if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CW'(1);
                end
                // cpu_ba wins over a timeout landing on the same cycle
                if (cpu_ba) begin
                    state_n = any_req ? S_GRANT : S_RELEASE;
                end else if (cnt == HALT_LAST) begin
                    timeout_err_n = 1'b1;
                    cpu_halt_n    = 1'b0;
                    state_n       = S_IDLE;
                end
            end

            S_GRANT: begin
                cpu_halt_n = 1'b1;
                cnt_n      = '0;
                if (vid_req) begin
                    vid_gnt_n = 1'b1;
                    bus_sel_n = SEL_VID;
                    state_n   = S_OWNED;
                end else if (req[0] && req[1]) begin
                    gnt_n     = rr ? 2'b10 : 2'b01;
                    bus_sel_n = rr ? SEL_R1 : SEL_R0;
                    state_n   = S_OWNED;
                end else if (req[0]) begin
                    gnt_n     = 2'b01;
                    bus_sel_n = SEL_R0;
                    state_n   = S_OWNED;
                end else if (req[1]) begin
                    gnt_n     = 2'b10;
                    bus_sel_n = SEL_R1;
                    state_n   = S_OWNED;
                end else begin
                    state_n = S_RELEASE;
                end
            end

            S_OWNED: begin
                // cpu_ba is deliberately ignored here; the CPU stays halted
                cpu_halt_n = 1'b1;
                case (bus_sel)
                    SEL_VID: begin
                        if (!vid_req) begin
                            vid_gnt_n = 1'b0;
                            bus_sel_n = SEL_CPU;
                            state_n   = S_GRANT;
                        end
                    end
                    SEL_R0, SEL_R1: begin
                        if (!own_req || (burst_done && (vid_req || other_req))) begin
                            gnt_n     = 2'b00;
                            bus_sel_n = SEL_CPU;
                            rr_n      = ~own_idx;
                            state_n   = S_GRANT;
                        end else if (!burst_done) begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                    default: begin
                        vid_gnt_n = 1'b0;
                        gnt_n     = 2'b00;
                        bus_sel_n = SEL_CPU;
                        state_n   = S_GRANT;
                    end
                endcase
            end

            S_RELEASE: begin
                cpu_halt_n = 1'b0;
                vid_gnt_n  = 1'b0;
                gnt_n      = 2'b00;
                bus_sel_n  = SEL_CPU;
                state_n    = S_IDLE;
            end

            default: begin
                cpu_halt_n = 1'b0;
                vid_gnt_n  = 1'b0;
                gnt_n      = 2'b00;
                bus_sel_n  = SEL_CPU;
                state_n    = S_IDLE;
            end
        endcase
    end

    // State, counter, round-robin pointer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rr          <= 1'b0;
            cpu_halt    <= 1'b0;
            vid_gnt     <= 1'b0;
            gnt         <= 2'b00;
            bus_sel     <= SEL_CPU;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rr          <= rr_n;
            cpu_halt    <= cpu_halt_n;
            vid_gnt     <= vid_gnt_n;
            gnt         <= gnt_n;
            bus_sel     <= bus_sel_n;
            timeout_err <= timeout_err_n;
        end
    end

endmodule

// File: doc/vram_bus_arbiter.md
Name: vram_bus_arbiter

Overview:
- Shares the single external memory bus between the CPU and three DMA masters: the video DMA (vpu hold/vramcs path), secondary requester 0, and secondary requester 1.
- Parks the bus on the CPU by default. It halts the CPU through the 6800-style HALT/BA handshake before granting a DMA master.
- Video DMA has fixed top priority and is never preempted. The two secondary requesters are round-robin and burst-limited.
- Drives the bus-owner select that steers the address/data muxes in the top level.

Parameters:
- HALT_TIMEOUT, 64: cycles to wait for cpu_ba after asserting cpu_halt before aborting.
- MAX_BURST, 16: maximum consecutive granted cycles for a secondary requester when another requester is waiting.
- CW, 7: width of the shared timeout/burst counter; must satisfy 2^CW > max(HALT_TIMEOUT, MAX_BURST).

Ports:
- clk, in, 1: system clock; single clock domain.
- rst, in, 1: reset; synchronous, active-high.
- cpu_ba, in, 1: CPU bus-available; high while the CPU has tristated the bus.
- cpu_halt, out, 1: CPU halt request (registered).
- vid_req, in, 1: video DMA request (vpu hold).
- vid_gnt, out, 1: video DMA grant (registered).
- req, in, 2: secondary requests, one bit per requester.
- gnt, out, 2: secondary grants (registered, one-hot or zero).
- bus_sel, out, 2: bus owner; 0 = CPU, 1 = video, 2 = req0, 3 = req1.
- timeout_err, out, 1: one-cycle pulse on HALT_TIMEOUT expiry.

Behaviour:
- Reset values: cpu_halt=0, vid_gnt=0, gnt=0, bus_sel=0, timeout_err=0, state=IDLE, rr pointer=0, counter=0.
- Reset mid-grant drops all grants on the next edge. Requesters must tolerate a grant vanishing on reset.
- All outputs are registered and change only on a clk edge.
- At most one of vid_gnt/gnt[0]/gnt[1] is high in any cycle.
- bus_sel is 0 whenever no grant is high.
- "Any request" means vid_req | req[0] | req[1].
- State IDLE: cpu_halt=0.
  - Any request -> HALTING; cpu_halt=1 from the next cycle; counter cleared.
- State HALTING: cpu_halt=1; counter increments each cycle.
  - cpu_ba=1 and any request -> GRANT.
  - cpu_ba=1 and no request -> RELEASE.
  - cpu_ba=0 and counter == HALT_TIMEOUT-1 -> timeout_err=1 for one cycle, cpu_halt=0, -> IDLE.
  - The timeout check applies only while cpu_ba=0; cpu_ba arriving on the timeout cycle wins.
- State GRANT (arbitration cycle; no grant asserted; cpu_halt=1):
  - If vid_req=1, the winner is video.
  - Otherwise, if both req bits are set, the winner is the requester indexed by rr.
  - Otherwise, the winner is the single requester.
  - Next cycle: the winner's grant=1, bus_sel set accordingly, counter cleared, -> OWNED.
  - No request -> RELEASE.
- State OWNED: grant held.
  - Owner's request drops -> grant=0 next cycle, -> GRANT (re-arbitrate, CPU stays halted).
  - Secondary owner: counter increments each cycle. When counter == MAX_BURST-1 and another request (vid_req or the other req bit) is pending, preempt: grant=0 next cycle, -> GRANT.
  - With no competitor, a secondary may exceed MAX_BURST; the counter saturates.
  - Video owner is never preempted and its cycles are not counted.
  - When a secondary grant ends for any reason, rr is set to the other requester.
- State RELEASE: cpu_halt=0, bus_sel=0 next cycle, -> IDLE.
  - IDLE must then see a request before re-halting; this gives at least one CPU-free cycle between halt episodes.
- Latency:
  - Request sampled in IDLE at edge N -> cpu_halt high after edge N.
  - cpu_ba first sampled high at edge M -> grant high after edge M+1 (one GRANT cycle).
  - Owner request drop at edge K -> grant low after K; the next owner's grant is high after K+1.
- cpu_ba falling while in OWNED is ignored; the arbiter keeps cpu_halt asserted.
- A request that deasserts during HALTING before cpu_ba arrives is treated as absent at the GRANT decision.

Test Plan:
- Reset mid-OWNED: assert rst for 1 cycle during a video grant -> all grants=0, cpu_halt=0, bus_sel=0 after that edge; arbitration resumes cleanly afterwards.
- Video request: vid_req=1, cpu_ba rises 3 cycles after cpu_halt -> vid_gnt=1 and bus_sel=1 exactly 1 cycle after cpu_ba is sampled. Drop vid_req -> vid_gnt=0, then RELEASE, cpu_halt=0, bus_sel=0.
- Round robin with burst limit (MAX_BURST=16): req=2'b11 held continuously -> gnt alternates 01, 10, 01; each grant lasts 16 cycles with one dead cycle between; cpu_halt stays 1 throughout.
- Video preemption: req0 owns the bus for 5 cycles, then vid_req=1 -> req0 is kept until its 16th cycle, then preempted; vid_gnt follows after one dead cycle. With vid_req held for 100 cycles, vid_gnt stays high for all 100.
- Halt timeout (HALT_TIMEOUT=64): req0=1, cpu_ba held 0 -> timeout_err pulses exactly once on the 64th HALTING cycle, cpu_halt=0, no grant ever issued. Repeat with cpu_ba arriving on cycle 64 -> grant issued, no timeout_err.
- Request withdrawn while halting: req1 pulses 1 cycle, cpu_ba arrives later -> no grant, RELEASE, cpu_halt=0 one cycle later.
